// File: rtl/if_stage_pkg.sv
// Shared widths, FSM encoding, IF/ID payload and helpers for the fetch stage.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  // Fetch FSM: IDLE after reset, FETCH requesting, DROP waiting out a
  // request whose word is unwanted, HOLD parked on the skid buffer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // IF/ID pipeline register payload.
  typedef struct packed {
    logic            valid;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } if_id_t;

  // Clear the byte-offset bits of an address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush > stall > load > bubble.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [ILEN-1:0] word,
  input  logic [XLEN-1:0] next_pc4,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] pc4,
  output logic            valid
);

  if_id_t r;
  if_id_t r_nxt;

  // Select the next register contents by priority.
  always_comb begin
    r_nxt = r;
    if (flush) begin
      r_nxt.valid = 1'b0;
      r_nxt.instr = NOP_INSTR;
      r_nxt.pc4   = '0;
    end else if (stall) begin
      r_nxt = r;
    end else if (load) begin
      r_nxt.valid = 1'b1;
      r_nxt.instr = word;
      r_nxt.pc4   = next_pc4;
    end else begin
      r_nxt.valid = 1'b0;
      r_nxt.instr = NOP_INSTR;
    end
  end

  // Register with asynchronous reset to an empty bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r.valid <= 1'b0;
      r.instr <= NOP_INSTR;
      r.pc4   <= '0;
    end else begin
      r <= r_nxt;
    end
  end

  assign instr = r.instr;
  assign pc4   = r.pc4;
  assign valid = r.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, req/ack fetch FSM with skid buffer and
// redirect handling, feeding the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc4,
  output logic            if_id_valid
);

  localparam logic [XLEN-1:0] RESET_PC_AL = {RESET_PC[XLEN-1:2], 2'b00};

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] tgt_nxt;
  logic [ILEN-1:0] skid;
  logic [ILEN-1:0] skid_nxt;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_al;
  logic            deliver;
  logic [ILEN-1:0] deliver_word;

  assign pc_inc      = pc + PC_STEP;
  assign redirect_al = word_align(redirect_pc);

  // Request is a pure decode of registered state so reset kills it at once.
  assign imem_req  = (state == ST_FETCH) || (state == ST_DROP);
  assign imem_addr = pc;

  // Next-state, PC, redirect target, skid buffer and delivery selection.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    tgt_nxt      = tgt;
    skid_nxt     = skid;
    deliver      = 1'b0;
    deliver_word = NOP_INSTR;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_nxt = redirect_al;
          end else if (stall) begin
            skid_nxt  = imem_rdata;
            state_nxt = ST_HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
            pc_nxt       = pc_inc;
          end
        end else if (redirect) begin
          // Address must stay put until ack, so park the target.
          tgt_nxt   = redirect_al;
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          tgt_nxt = redirect_al;
        end
        if (imem_ack) begin
          pc_nxt    = redirect ? redirect_al : tgt;
          state_nxt = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_nxt    = redirect_al;
          state_nxt = ST_FETCH;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliver_word = skid;
          pc_nxt       = pc_inc;
          state_nxt    = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC_AL;
      tgt   <= '0;
      skid  <= NOP_INSTR;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      tgt   <= tgt_nxt;
      skid  <= skid_nxt;
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall    (stall),
    .load     (deliver),
    .word     (deliver_word),
    .next_pc4 (pc_inc),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a transaction-level model predicts the
// post-edge outputs each cycle; a negedge monitor compares.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int errors = 0;
  int checks = 0;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns address + 0x100 whenever requested.
  assign imem_rdata = imem_req ? (imem_addr + 32'h100) : 32'hDEAD_BEEF;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t q[$];

  // Reference model: where fetching is, whether a word is parked, whether
  // the outstanding request is to be thrown away, and the IF/ID contents.
  bit          m_started, m_parked, m_discard;
  logic [31:0] m_pc, m_target, m_parked_word;
  bit          m_valid;
  logic [31:0] m_instr, m_pc4;

  function automatic bit m_req();
    return m_started && !m_parked;
  endfunction

  task automatic model_reset();
    m_started = 0; m_parked = 0; m_discard = 0;
    m_pc = RST_PC; m_target = 0; m_parked_word = 0;
    m_valid = 0; m_instr = 0; m_pc4 = 0;
  endtask

  task automatic model_step(input bit a, input bit s, input bit f, input bit r,
                            input logic [31:0] t);
    bit          got, give;
    logic [31:0] word, dest;
    got  = m_req() && a;
    give = 0;
    word = 0;
    dest = {t[31:2], 2'b00};
    if (!m_started) begin
      m_started = 1;
    end else if (m_parked) begin
      if (r) begin
        m_parked = 0; m_pc = dest;
      end else if (!s) begin
        give = 1; word = m_parked_word; m_parked = 0;
      end
    end else if (m_discard) begin
      if (r) m_target = dest;
      if (got) begin
        m_pc = m_target; m_discard = 0;
      end
    end else if (got) begin
      if (r) m_pc = dest;
      else if (s) begin
        m_parked = 1; m_parked_word = mem_word(m_pc);
      end else begin
        give = 1; word = mem_word(m_pc);
      end
    end else if (r) begin
      m_discard = 1; m_target = dest;
    end
    if (f) begin
      m_valid = 0; m_instr = 0; m_pc4 = 0;
    end else if (s) begin
      // IF/ID frozen
    end else if (give) begin
      m_valid = 1; m_instr = word; m_pc4 = m_pc + 32'd4;
    end else begin
      m_valid = 0; m_instr = 0;
    end
    if (give) m_pc = m_pc + 32'd4;
  endtask

  task automatic push_exp();
    exp_t e;
    e.pc = m_pc; e.req = m_req(); e.valid = m_valid;
    e.instr = m_instr; e.pc4 = m_pc4;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances on the same edge as the DUT.
  task automatic cycle(input bit a, input bit s, input bit f, input bit r,
                       input logic [31:0] t);
    imem_ack = a; stall = s; flush = f; redirect = r; redirect_pc = t;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(a, s, f, r, t);
    push_exp();
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc", pc, e.pc);
        check("imem_req", {31'b0, imem_req}, {31'b0, e.req});
        if (e.req) check("imem_addr", imem_addr, e.pc);
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
        check("if_id_instr", if_id_instr, e.instr);
        check("if_id_pc4", if_id_pc4, e.pc4);
      end
    end
  end

  initial begin
    logic [31:0] t;
    int          ack_pct, stall_pct, red_pct, fl_pct;
    rst = 1'b1;
    imem_ack = 0; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
    model_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    rst = 1'b0;

    // Zero-wait run across the address wrap, then flush+redirect to 0x11.
    repeat (4) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 32'h11);
    repeat (3) cycle(1, 0, 0, 0, 0);
    // Ack every third cycle.
    repeat (3) begin
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
    end
    // Stall across an ack, then release.
    repeat (3) cycle(1, 1, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0);
    // Redirect to 0x40 while a request is unacked.
    cycle(0, 0, 0, 1, 32'h40);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0);

    // Randomized phases with varying event densities.
    for (int p = 0; p < 4; p++) begin
      ack_pct   = (p == 0) ? 90 : (p == 1) ? 40 : (p == 2) ? 70 : 100;
      stall_pct = (p == 2) ? 40 : 15;
      red_pct   = (p == 1) ? 25 : 10;
      fl_pct    = 8;
      for (int c = 0; c < 300; c++) begin
        t = $urandom;
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
        cycle($urandom_range(0, 99) < ack_pct,
              $urandom_range(0, 99) < stall_pct,
              $urandom_range(0, 99) < fl_pct,
              $urandom_range(0, 99) < red_pct, t);
      end
    end

    // Asynchronous reset while parked on the skid buffer.
    for (int c = 0; c < 12; c++) begin
      if (m_parked) break;
      cycle(1, 1, 0, 0, 0);
    end
    if (!m_parked) begin
      checks++; errors++;
      $display("FAIL hold_entry: got not_parked expected parked");
    end
    #5;
    rst = 1'b1;
    #1;
    check("async_rst_req", {31'b0, imem_req}, 32'd0);
    check("async_rst_valid", {31'b0, if_id_valid}, 32'd0);
    check("async_rst_pc", pc, RST_PC);
    cycle(0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (6) cycle(1, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    check("queue_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
